// File: rtl/imem_loadable_if.sv
// Byte-stream programming port of the loadable instruction memory.
// The master side sources the load controls and bytes; the memory answers with prog_ready.
interface imem_loadable_if;
  logic       load_start;
  logic       load_end;
  logic       prog_valid;
  logic [7:0] prog_byte;
  logic       prog_ready;

  modport master (
    output load_start,
    output load_end,
    output prog_valid,
    output prog_byte,
    input  prog_ready
  );

  modport slave (
    input  load_start,
    input  load_end,
    input  prog_valid,
    input  prog_byte,
    output prog_ready
  );
endinterface

// File: rtl/imem_loadable.sv
// Instruction memory with combinational fetch and a byte-stream loader that
// packs little-endian bytes into N-bit words written from address 0 upward.
module imem_loadable #(
  parameter int N         = 32,
  parameter int DEPTH     = 128,
  parameter int AW        = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        addr,
  output logic [N-1:0]         q,
  imem_loadable_if.slave       prog,
  output logic                 hold,
  output logic                 done,
  output logic [AW:0]          words_loaded,
  output logic                 err_partial,
  output logic                 err_overflow
);

  localparam int BW  = N / 8;
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  logic [N-1:0]   mem [DEPTH];
  state_t         state, state_next;
  logic [AW-1:0]  wptr;
  logic [BCW-1:0] bcnt;
  logic [N-1:0]   asm_word, word_next;
  logic           accept, last_byte, at_top, ending, partial_at_end;

  always_comb begin
    accept         = prog.prog_valid && prog.prog_ready && !prog.load_start;
    last_byte      = accept && (bcnt == BCW'(BW - 1));
    at_top         = (wptr == AW'(DEPTH - 1));
    ending         = prog.load_end && !prog.load_start && (state != IDLE);
    // byte count as it stands after a same-cycle byte has been counted
    partial_at_end = accept ? !last_byte : (bcnt != '0);
    word_next      = asm_word;
    word_next[{bcnt, 3'b000} +: 8] = prog.prog_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (prog.load_start)                    state_next = LOAD;
    else if (ending)                        state_next = IDLE;
    else if (state == LOAD && last_byte && at_top) state_next = FULL;
  end

  always_comb begin
    prog.prog_ready = (state == LOAD);
    hold            = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      bcnt         <= '0;
      asm_word     <= '0;
      words_loaded <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
      done         <= 1'b0;
    end else if (prog.load_start) begin
      wptr         <= '0;
      bcnt         <= '0;
      asm_word     <= '0;
      words_loaded <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= ending;
      if (accept) begin
        if (last_byte) begin
          bcnt         <= '0;
          asm_word     <= '0;
          words_loaded <= words_loaded + 1'b1;
          if (!at_top) wptr <= wptr + 1'b1;
        end else begin
          bcnt     <= bcnt + 1'b1;
          asm_word <= word_next;
        end
      end
      if (ending) begin
        if (partial_at_end) err_partial <= 1'b1;
        bcnt     <= '0;
        asm_word <= '0;
      end
      if (state == FULL && prog.prog_valid) err_overflow <= 1'b1;
    end
  end

  // Storage has no reset: programmed words survive a controller reset.
  always_ff @(posedge clk) begin
    if (last_byte) mem[wptr] <= word_next;
  end

  assign q = mem[addr];

endmodule

// File: tb/tb_imem_loadable.sv
// Randomised and directed bench for imem_loadable with a byte-level reference model
// and a done-event scoreboard.
module tb_imem_loadable;
  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int BW    = N / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [N-1:0]  q;
  logic          hold, done, err_partial, err_overflow;
  logic [AW:0]   words_loaded;

  imem_loadable_if prog();

  imem_loadable #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .q(q), .prog(prog),
    .hold(hold), .done(done), .words_loaded(words_loaded),
    .err_partial(err_partial), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int unsigned cyc;
    int unsigned words;
    bit          partial;
    bit          ovf;
  } exp_t;
  exp_t expq[$];

  // Reference model: memory image plus the list-level view of the current load.
  logic [N-1:0] mmem [DEPTH];
  bit           m_loading = 0;
  int unsigned  m_acc = 0;
  bit           m_ovf = 0, m_partial = 0;
  logic [N-1:0] m_word = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = expq.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("done_words", 64'(words_loaded), 64'(e.words));
        check("done_err_partial", 64'(err_partial), 64'(e.partial));
        check("done_err_overflow", 64'(err_overflow), 64'(e.ovf));
      end
    end
  end

  task automatic check_state();
    check("hold", 64'(hold), 64'(m_loading));
    check("prog_ready", 64'(prog.prog_ready), 64'(m_loading && m_acc < DEPTH * BW));
    check("words_loaded", 64'(words_loaded), 64'(m_acc / BW));
    check("err_partial", 64'(err_partial), 64'(m_partial));
    check("err_overflow", 64'(err_overflow), 64'(m_ovf));
    check("q_fetch", 64'(q), 64'(mmem[addr]));
  endtask

  // One clock cycle of stimulus; model is advanced with what the edge should do.
  task automatic step(bit ls, bit le, bit pv, logic [7:0] pb);
    bit was_loading;
    was_loading     = m_loading;
    prog.load_start = ls;
    prog.load_end   = le;
    prog.prog_valid = pv;
    prog.prog_byte  = pb;
    addr            = AW'($urandom_range(0, DEPTH - 1));
    if (ls) begin
      m_loading = 1; m_acc = 0; m_ovf = 0; m_partial = 0; m_word = '0;
    end else if (m_loading) begin
      if (pv) begin
        if (m_acc == DEPTH * BW) m_ovf = 1;
        else begin
          m_word[8 * (m_acc % BW) +: 8] = pb;
          m_acc++;
          if (m_acc % BW == 0) begin
            mmem[m_acc / BW - 1] = m_word;
            m_word = '0;
          end
        end
      end
      if (le) begin
        m_loading = 0;
        m_partial = (m_acc % BW) != 0;
        m_word    = '0;
      end
    end
    @(posedge clk); #1;
    if (!ls && le && was_loading) expq.push_back('{cyc, m_acc / BW, m_partial, m_ovf});
    prog.load_start = 0;
    prog.load_end   = 0;
    prog.prog_valid = 0;
    check_state();
  endtask

  task automatic send(logic [7:0] b);
    step(0, 0, 1, b);
  endtask

  task automatic read_word(int unsigned a, logic [N-1:0] exp, string name);
    addr = AW'(a);
    #1;
    check(name, 64'(q), 64'(exp));
  endtask

  task automatic verify_all();
    for (int unsigned a = 0; a < DEPTH; a++) read_word(a, mmem[a], "mem_image");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 0;
    m_loading = 0; m_acc = 0; m_ovf = 0; m_partial = 0; m_word = '0;
    #1;
    check("rst_hold", 64'(hold), 64'(0));
    check("rst_ready", 64'(prog.prog_ready), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_words", 64'(words_loaded), 64'(0));
    check("rst_errs", 64'({err_partial, err_overflow}), 64'(0));
    @(posedge clk); #1;
    reset = 1;
  endtask

  initial begin
    logic [7:0] two_word [8];
    two_word = '{8'h01, 8'h00, 8'h00, 8'hf8, 8'h02, 8'h80, 8'h00, 8'hf8};
    for (int unsigned a = 0; a < DEPTH; a++) mmem[a] = '0;
    prog.load_start = 0; prog.load_end = 0; prog.prog_valid = 0; prog.prog_byte = '0;

    // reset values with no image loaded
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", 64'(hold), 64'(0));
    check("rst_words", 64'(words_loaded), 64'(0));
    reset = 1;
    @(posedge clk); #1;
    check_state();
    check("idle_done", 64'(done), 64'(0));
    for (int unsigned a = 0; a < DEPTH; a++) read_word(a, '0, "mem_powerup_zero");

    // two-word load
    step(1, 0, 0, 0);
    foreach (two_word[i]) send(two_word[i]);
    step(0, 1, 0, 0);
    read_word(0, 32'hf8000001, "two_word_mem0");
    read_word(1, 32'hf8008002, "two_word_mem1");
    check("two_word_count", 64'(words_loaded), 64'(2));

    // partial word: second word never lands
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
    step(0, 1, 0, 0);
    read_word(1, 32'hf8008002, "partial_mem1_kept");
    check("partial_flag", 64'(err_partial), 64'(1));
    verify_all();

    // fill to full, then one overflowing byte
    step(1, 0, 0, 0);
    for (int i = 0; i < DEPTH * BW; i++) send(8'(i + 8'h40));
    check("full_ready_low", 64'(prog.prog_ready), 64'(0));
    check("full_words", 64'(words_loaded), 64'(DEPTH));
    send(8'hee);
    check("overflow_flag", 64'(err_overflow), 64'(1));
    read_word(0, 32'h43424140, "overflow_mem0_kept");
    step(0, 1, 0, 0);
    verify_all();

    // restart mid-word with a byte offered on the restart cycle
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) send(8'(8'h70 + i));
    step(1, 0, 1, 8'h99);
    send(8'haa); send(8'hbb); send(8'hcc); send(8'hdd);
    step(0, 1, 0, 0);
    read_word(0, 32'hddccbbaa, "restart_mem0");
    check("restart_words", 64'(words_loaded), 64'(1));

    // reset in the middle of the second word
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) send(8'(8'h11 + i));
    do_reset();
    read_word(0, 32'h14131211, "reset_mem0_kept");
    verify_all();

    // load_end on the last byte of a word, and load_end while idle
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(8'(8'hc0 + i));
    step(0, 1, 1, 8'hc3);
    read_word(0, 32'hc3c2c1c0, "end_with_byte_mem0");
    step(0, 1, 0, 0);
    step(1, 1, 1, 8'h5a);
    step(0, 1, 0, 0);

    // randomised loads with gaps, restarts and same-cycle end bytes
    for (int ld = 0; ld < 40; ld++) begin
      int unsigned nb;
      step(1, 0, 0, 0);
      nb = $urandom_range(0, DEPTH * BW + 6);
      for (int unsigned b = 0; b < nb; b++) begin
        if ($urandom_range(0, 99) < 3) step(1, 0, 1, 8'($urandom));
        else step(0, 0, ($urandom_range(0, 3) != 0), 8'($urandom));
      end
      step(($urandom_range(0, 9) == 0), 1, $urandom_range(0, 1) == 1, 8'($urandom));
      if (m_loading) step(0, 1, 0, 0);
      repeat ($urandom_range(0, 2)) step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
      if (ld % 8 == 7) verify_all();
    end
    verify_all();

    repeat (3) step(0, 0, 0, 0);
    check("done_queue_drained", 64'(expq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
